// File: rtl/psd_pkg.sv
// rtl/psd_pkg.sv - shared constants and FSM encoding for the sqrt / square-check datapath
//   PSD_NBITS   : default radicand / square width
//   PSD_ROOT_W  : default root width (PSD_NBITS/2)
//   psd_state_t : IDLE/RUN/DONE encoding, also used by the square-root controller
package psd_pkg;

   localparam int PSD_NBITS  = 32;
   localparam int PSD_ROOT_W = PSD_NBITS / 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } psd_state_t;

endpackage

// File: rtl/psd_bracket.sv
// rtl/psd_bracket.sv - combinational residual and floor-sqrt bracket test
//   i_x        : radicand
//   i_acc      : candidate square (root^2)
//   i_mcand    : candidate root
//   o_residual : (i_x - i_acc) mod 2^NBITS
//   o_ok       : i_acc <= i_x < i_acc + 2*i_mcand + 1
module psd_bracket
   import psd_pkg::*;
#(
   parameter int NBITS = PSD_NBITS
) (
   input  logic [NBITS-1:0]   i_x,
   input  logic [NBITS-1:0]   i_acc,
   input  logic [NBITS/2-1:0] i_mcand,
   output logic [NBITS-1:0]   o_residual,
   output logic               o_ok
);

   localparam int RW = NBITS / 2;

   // One extra bit so that root = 2^RW-1 yields a bound of exactly 2^NBITS.
   logic [NBITS:0] w_upper;

   assign w_upper    = {1'b0, i_acc} + {{RW{1'b0}}, i_mcand, 1'b0} + (NBITS+1)'(1);
   assign o_residual = i_x - i_acc;
   assign o_ok       = (i_x >= i_acc) && ({1'b0, i_x} < w_upper);

endmodule

// File: rtl/psdsquare.sv
// rtl/psdsquare.sv - sequential shift-and-add squarer with floor-sqrt result check
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset
//   start    : request, sampled in IDLE or DONE
//   root     : candidate root (NBITS/2), captured on accept
//   xin      : radicand (NBITS), captured on accept
//   busy     : high while squaring (NBITS/2 cycles)
//   done     : one-cycle pulse, results valid from this cycle
//   sq       : root^2, held until the next result
//   residual : (xin - sq) mod 2^NBITS, held
//   ok       : root is the floor square root of xin, held
module psdsquare
   import psd_pkg::*;
#(
   parameter int NBITS = PSD_NBITS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [NBITS/2-1:0] root,
   input  logic [NBITS-1:0]   xin,
   output logic               busy,
   output logic               done,
   output logic [NBITS-1:0]   sq,
   output logic [NBITS-1:0]   residual,
   output logic               ok
);

   localparam int RW = NBITS / 2;
   localparam int CW = $clog2(RW) + 1;

   psd_state_t      r_state;
   psd_state_t      w_state_next;
   logic            w_accept;
   logic            w_last;

   logic [RW-1:0]    r_mcand;
   logic [RW-1:0]    r_mplier;
   logic [NBITS-1:0] r_x;
   logic [NBITS-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [NBITS-1:0] r_sq;
   logic [NBITS-1:0] r_residual;
   logic             r_ok;

   logic [CW-1:0]    w_shamt;
   logic [NBITS-1:0] w_partial;
   logic [NBITS-1:0] w_acc_next;
   logic [NBITS-1:0] w_residual;
   logic             w_ok;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // start is deliberately ignored here; nothing is queued.
            if (r_cnt == CW'(1)) begin
               w_last       = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Bit position of the current multiplier LSB: 0 on the first RUN cycle.
   assign w_shamt    = CW'(RW) - r_cnt;
   assign w_partial  = {{RW{1'b0}}, r_mcand} << w_shamt;
   assign w_acc_next = r_mplier[0] ? (r_acc + w_partial) : r_acc;

   // Bracket is evaluated on the post-add accumulator so the DONE-entry edge
   // sees the complete square.
   psd_bracket #(
      .NBITS (NBITS)
   ) u_bracket (
      .i_x        (r_x),
      .i_acc      (w_acc_next),
      .i_mcand    (r_mcand),
      .o_residual (w_residual),
      .o_ok       (w_ok)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_x        <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sq       <= '0;
         r_residual <= '0;
         r_ok       <= 1'b0;
      end else begin
         r_busy <= (w_state_next == ST_RUN);
         r_done <= (w_state_next == ST_DONE);
         if (w_accept) begin
            r_mcand  <= root;
            r_mplier <= root;
            r_x      <= xin;
            r_acc    <= '0;
            r_cnt    <= CW'(RW);
         end else if (r_state == ST_RUN) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (w_last) begin
               r_sq       <= w_acc_next;
               r_residual <= w_residual;
               r_ok       <= w_ok;
            end
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign sq       = r_sq;
   assign residual = r_residual;
   assign ok       = r_ok;

endmodule
